// File: rtl/wbuf_pkg.sv
// Shared types and default sizing for the DRAM write buffer controller.
// Entry layout and drain FSM encoding live here so all blocks agree.
package wbuf_pkg;

    localparam int WB_NUM_ENTRIES = 8;
    localparam int WB_ADDR_W      = 32;
    localparam int WB_DATA_W      = 64;
    localparam int WB_BURST_LEN   = 4;

    typedef struct packed {
        logic                              valid;
        logic                              issued;
        logic [WB_ADDR_W-1:0]              addr;
        logic [WB_DATA_W*WB_BURST_LEN-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        D_IDLE,
        D_BURST
    } drain_state_e;

endpackage

// File: rtl/wb_lsb_select.sv
// Lowest-set-bit finder over an entry mask.
// Returns index 0 with any_set=0 for an empty mask.
module wb_lsb_select #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] mask,
    output logic [W-1:0] idx,
    output logic         any_set
);

    always_comb begin
        idx     = '0;
        any_set = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx     = W'(i);
                any_set = 1'b1;
            end
        end
    end

endmodule

// File: rtl/write_buf_ctrl.sv
// DRAM write buffer controller: allocates bursts, issues commands in
// index order, and drains data beats on scheduler write-data phases.
module write_buf_ctrl
    import wbuf_pkg::*;
#(
    parameter int NUM_ENTRIES = WB_NUM_ENTRIES,
    parameter int ADDR_W      = WB_ADDR_W,
    parameter int DATA_W      = WB_DATA_W,
    parameter int BURST_LEN   = WB_BURST_LEN,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W*BURST_LEN-1:0] wr_data,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic [ADDR_W-1:0]           cmd_addr,
    output logic [IDX_W-1:0]            cmd_id,
    input  logic                        wdata_req,
    output logic                        wdata_valid,
    output logic [DATA_W-1:0]           wdata,
    output logic                        wdata_last,
    output logic [IDX_W-1:0]            wdata_id,
    output logic                        full,
    output logic                        empty,
    output logic [IDX_W:0]              count,
    output logic                        err_underrun
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int PW     = IDX_W + 1;
    localparam logic [PW-1:0]     FULL_CNT = PW'(NUM_ENTRIES);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    wb_entry_t ent [NUM_ENTRIES];

    drain_state_e state, state_nxt;
    logic [IDX_W-1:0]  sel;
    logic [BEAT_W-1:0] beat;
    logic [PW-1:0]     pending;
    logic [PW-1:0]     pend_nxt;
    logic [PW:0]       tot;
    logic [PW:0]       rem;

    logic [NUM_ENTRIES-1:0] vld, iss, hi_mask;
    logic [NUM_ENTRIES-1:0] free_mask, cand_mask, drain_mask;
    logic [NUM_ENTRIES-1:0] sel_oh, alloc_oh, vld_nxt;
    logic                   seen;

    logic [IDX_W-1:0] free_idx, cand_idx, drain_idx;
    logic             free_any, cand_any, drain_any;

    logic          alloc, last, try_start, start, underrun;
    logic [PW-1:0] cnt_nxt;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            vld[i] = ent[i].valid;
            iss[i] = ent[i].issued;
        end
    end

    // hi_mask[i] is set when no issued entry sits at or above i,
    // so new commands only ever go above the newest issued one.
    always_comb begin
        seen    = 1'b0;
        hi_mask = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            hi_mask[i] = !seen;
            if (vld[i] && iss[i]) seen = 1'b1;
        end
    end

    always_comb begin
        sel_oh = '0;
        if (state == D_BURST) sel_oh[sel] = 1'b1;
    end

    assign free_mask  = ~vld;
    assign cand_mask  = vld & ~iss & hi_mask;
    assign drain_mask = vld & iss & ~sel_oh;

    wb_lsb_select #(.N(NUM_ENTRIES), .W(IDX_W)) u_free (
        .mask    (free_mask),
        .idx     (free_idx),
        .any_set (free_any)
    );

    wb_lsb_select #(.N(NUM_ENTRIES), .W(IDX_W)) u_cand (
        .mask    (cand_mask),
        .idx     (cand_idx),
        .any_set (cand_any)
    );

    wb_lsb_select #(.N(NUM_ENTRIES), .W(IDX_W)) u_drain (
        .mask    (drain_mask),
        .idx     (drain_idx),
        .any_set (drain_any)
    );

    assign wr_ready = !full;
    assign alloc    = wr_valid && wr_ready && free_any;
    assign last     = (state == D_BURST) && (beat == LAST_BEAT);

    always_comb begin
        tot       = {1'b0, pending} + {{PW{1'b0}}, wdata_req};
        try_start = ((state == D_IDLE) || last) && (tot != '0);
        start     = try_start && drain_any;
        underrun  = try_start && !drain_any;
        rem       = tot - {{PW{1'b0}}, try_start};
        pend_nxt  = (rem > {1'b0, FULL_CNT}) ? FULL_CNT : rem[PW-1:0];
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            D_IDLE:  if (start) state_nxt = D_BURST;
            D_BURST: if (last && !start) state_nxt = D_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= D_IDLE;
            sel          <= '0;
            beat         <= '0;
            pending      <= '0;
            err_underrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pend_nxt;
            if (underrun) err_underrun <= 1'b1;
            if (start) begin
                sel  <= drain_idx;
                beat <= '0;
            end else if (last) begin
                beat <= '0;
            end else if (state == D_BURST) begin
                beat <= beat + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) ent[i] <= '0;
        end else begin
            if (alloc) begin
                ent[free_idx].valid  <= 1'b1;
                ent[free_idx].issued <= 1'b0;
                ent[free_idx].addr   <= wr_addr;
                ent[free_idx].data   <= wr_data;
            end
            if (cmd_valid && cmd_ready) ent[cmd_id].issued <= 1'b1;
            if (last) begin
                ent[sel].valid  <= 1'b0;
                ent[sel].issued <= 1'b0;
            end
        end
    end

    // Command register holds until accepted; the next candidate
    // is picked from flags that already include the accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd_addr  <= '0;
            cmd_id    <= '0;
        end else if (cmd_valid) begin
            if (cmd_ready) cmd_valid <= 1'b0;
        end else if (cand_any) begin
            cmd_valid <= 1'b1;
            cmd_addr  <= ent[cand_idx].addr;
            cmd_id    <= cand_idx;
        end
    end

    always_comb begin
        alloc_oh = '0;
        if (alloc) alloc_oh[free_idx] = 1'b1;
        vld_nxt = (vld | alloc_oh) & ~(last ? sel_oh : '0);
        cnt_nxt = PW'($countones(vld_nxt));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            count <= cnt_nxt;
            full  <= (cnt_nxt == FULL_CNT);
            empty <= (cnt_nxt == '0);
        end
    end

    assign wdata_valid = (state == D_BURST);
    assign wdata_last  = last;
    assign wdata_id    = wdata_valid ? sel : '0;
    assign wdata       = wdata_valid ?
                         ent[sel].data[int'(beat)*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_write_buf_ctrl.sv
// Self-checking bench for write_buf_ctrl: command and beat scoreboards
// fed by the stimulus, checked by negedge monitors.
module tb_write_buf_ctrl;

    localparam int NE = 8;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BL = 4;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_valid = 1'b0;
    logic            wr_ready;
    logic [AW-1:0]   wr_addr = '0;
    logic [DW*BL-1:0] wr_data = '0;
    logic            cmd_valid;
    logic            cmd_ready = 1'b0;
    logic [AW-1:0]   cmd_addr;
    logic [IW-1:0]   cmd_id;
    logic            wdata_req = 1'b0;
    logic            wdata_valid;
    logic [DW-1:0]   wdata;
    logic            wdata_last;
    logic [IW-1:0]   wdata_id;
    logic            full;
    logic            empty;
    logic [IW:0]     count;
    logic            err_underrun;

    write_buf_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_id       (cmd_id),
        .wdata_req    (wdata_req),
        .wdata_valid  (wdata_valid),
        .wdata        (wdata),
        .wdata_last   (wdata_last),
        .wdata_id     (wdata_id),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .err_underrun (err_underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] id;
    } beat_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
    } cmd_t;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [DW*BL-1:0] data;
        int               id;
    } wvec_t;

    beat_t beat_q[$];
    cmd_t  cmd_q[$];
    logic [DW*BL-1:0] model [NE];
    wvec_t tbl [NE];

    int errors = 0;
    int checks = 0;
    int run = 0;
    int max_run = 0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (wdata_valid) begin
                run++;
                if (run > max_run) max_run = run;
                if (beat_q.size() == 0) begin
                    chk("unexp_beat", wdata_valid, 0);
                end else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    chk("beat_data", wdata, b.data);
                    chk("beat_last", wdata_last, b.last);
                    chk("beat_id", wdata_id, b.id);
                end
            end else begin
                run = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) begin
            if (cmd_q.size() == 0) begin
                chk("unexp_cmd", cmd_valid, 0);
            end else begin
                cmd_t c;
                c = cmd_q.pop_front();
                chk("cmd_id", cmd_id, c.id);
                chk("cmd_addr", cmd_addr, c.addr);
            end
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wdata_req = 1'b0;
        cmd_ready = 1'b0;
        beat_q.delete();
        cmd_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_write(input logic [AW-1:0] a,
                            input logic [DW*BL-1:0] d, input int id);
        int n;
        model[id] = d;
        cmd_q.push_back('{IW'(id), a});
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        n = 0;
        while (!wr_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wr_accept", wr_ready, 1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic push_burst(input int id);
        for (int k = 0; k < BL; k++)
            beat_q.push_back('{model[id][k*DW +: DW], k == BL - 1, IW'(id)});
    endtask

    task automatic wait_cmds();
        int n = 0;
        while (cmd_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cmds_done", cmd_q.size(), 0);
    endtask

    task automatic wait_beats();
        int n = 0;
        while (beat_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("beats_done", beat_q.size(), 0);
    endtask

    task automatic req_pulse();
        wdata_req = 1'b1;
        @(posedge clk); #1;
        wdata_req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NE; i++) begin
            tbl[i].addr = 32'h100 + i;
            tbl[i].data = {64'(32'hB000 + i*16 + 3), 64'(32'hB000 + i*16 + 2),
                           64'(32'hB000 + i*16 + 1), 64'(32'hB000 + i*16)};
            tbl[i].id   = i;
        end

        // Fill all entries, check reset state, order and full.
        do_reset();
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_wdata_valid", wdata_valid, 0);
        chk("rst_wdata_last", wdata_last, 0);
        chk("rst_err", err_underrun, 0);
        cmd_ready = 1'b1;
        for (int i = 0; i < NE; i++)
            do_write(tbl[i].addr, tbl[i].data, tbl[i].id);
        wait_cmds();
        chk("full_after_8", full, 1);
        chk("count_after_8", count, 8);
        chk("wr_ready_full", wr_ready, 0);
        wr_valid = 1'b1;
        wr_addr  = 32'h200;
        repeat (3) @(posedge clk); #1;
        chk("blocked_count", count, 8);
        chk("blocked_ready", wr_ready, 0);
        chk("blocked_no_cmd", cmd_valid, 0);
        wr_valid = 1'b0;
        for (int i = 0; i < NE; i++) push_burst(i);
        wdata_req = 1'b1;
        repeat (NE) @(posedge clk); #1;
        wdata_req = 1'b0;
        wait_beats();
        chk("drain_all_count", count, 0);
        chk("drain_all_empty", empty, 1);
        chk("drain_all_full", full, 0);

        // Single burst beat order and latency.
        do_reset();
        cmd_ready = 1'b1;
        do_write(32'h40, {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 0);
        wait_cmds();
        push_burst(0);
        chk("pre_req_idle", wdata_valid, 0);
        req_pulse();
        chk("first_beat_lat", wdata_valid, 1);
        chk("first_beat_data", wdata, 64'hD0);
        wait_beats();
        chk("single_count", count, 0);
        chk("single_empty", empty, 1);

        // Reallocated entry 0 waits behind issued 1..3.
        do_reset();
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            do_write(32'h300 + i, {4{64'(32'hC000 + i)}} + 256'(i), i);
        wait_cmds();
        push_burst(0);
        req_pulse();
        wait_beats();
        do_write(32'h3A0, {64'hE3, 64'hE2, 64'hE1, 64'hE0}, 0);
        repeat (5) @(posedge clk); #1;
        chk("no_early_issue", cmd_valid, 0);
        chk("realloc_count", count, 4);
        for (int i = 1; i < 4; i++) begin
            push_burst(i);
            req_pulse();
            wait_beats();
            if (i < 3) chk("still_blocked", cmd_valid, 0);
        end
        wait_cmds();
        push_burst(0);
        req_pulse();
        wait_beats();
        chk("order_count", count, 0);

        // Back-to-back requests chain without gaps.
        do_reset();
        cmd_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            do_write(32'h500 + i, {4{64'(32'hF00 + i)}} ^ 256'(i * 7), i);
        wait_cmds();
        for (int i = 0; i < 3; i++) push_burst(i);
        max_run = 0;
        wdata_req = 1'b1;
        repeat (3) @(posedge clk); #1;
        wdata_req = 1'b0;
        wait_beats();
        chk("contig_run", max_run, 12);
        repeat (6) @(posedge clk); #1;
        chk("no_extra_beat", wdata_valid, 0);
        chk("b2b_empty", empty, 1);

        // Request with nothing issued raises sticky underrun.
        do_reset();
        do_write(32'h600, {4{64'h11}}, 0);
        do_write(32'h601, {4{64'h22}}, 1);
        chk("held_cmd", cmd_valid, 1);
        req_pulse();
        chk("underrun_set", err_underrun, 1);
        chk("underrun_no_beat", wdata_valid, 0);
        repeat (5) @(posedge clk); #1;
        chk("underrun_sticky", err_underrun, 1);
        chk("underrun_no_beat2", wdata_valid, 0);
        chk("underrun_count", count, 2);

        // Reset in the middle of a burst.
        do_reset();
        cmd_ready = 1'b1;
        do_write(32'h700, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 0);
        wait_cmds();
        push_burst(0);
        req_pulse();
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk("beat2_active", wdata, 64'hA2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", wdata_valid, 0);
        chk("mid_rst_last", wdata_last, 0);
        chk("mid_rst_data", wdata, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_err", err_underrun, 0);
        chk("mid_rst_ready", wr_ready, 1);
        chk("mid_rst_cmd", cmd_valid, 0);
        beat_q.delete();
        cmd_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("post_rst_quiet", wdata_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
